// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DFLT   = 25;
  localparam int unsigned DEF_DIV_DFLT = 50;
  localparam int unsigned NUM_CH_MAX   = 8;

  // A zero divisor would never reach terminal count, so it behaves as 1.
  function automatic logic [31:0] div_clamp(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle between a divider host and clk_div_multi.
interface clk_div_multi_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 25,
  parameter int unsigned SEL_W  = 3
);

  logic              En;
  logic              SyncAll;
  logic              DivWr;
  logic [SEL_W-1:0]  DivSel;
  logic [CNT_W-1:0]  DivData;
  logic [NUM_CH-1:0] ClkOut;
  logic [NUM_CH-1:0] Tick;
  logic [NUM_CH-1:0] Pending;

  modport master (
    output En,
    output SyncAll,
    output DivWr,
    output DivSel,
    output DivData,
    input  ClkOut,
    input  Tick,
    input  Pending
  );

  modport slave (
    input  En,
    input  SyncAll,
    input  DivWr,
    input  DivSel,
    input  DivData,
    output ClkOut,
    output Tick,
    output Pending
  );

endinterface

// File: rtl/clk_div_multi_channel.sv
// One divider channel: half-period counter, active/shadow divisor, square wave and tick.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DFLT,
  parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             en,
  input  logic             sync_all,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] apply_div;
  logic             tc;

  // Active always holds a clamped (non-zero) value so TC is reachable.
  always_comb begin
    apply_div = wr ? CNT_W'(div_clamp(32'(wr_data))) : CNT_W'(div_clamp(32'(shadow)));
    tc        = (cnt == active - 1'b1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt     <= '0;
      active  <= DefDiv;
      shadow  <= DefDiv;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else if (sync_all) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      active  <= apply_div;
      if (wr) begin
        shadow <= wr_data;
      end
    end else begin
      tick <= 1'b0;
      if (wr) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end
      if (en) begin
        if (tc) begin
          // Divisor changes only land here, at a half-period boundary.
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
          active  <= apply_div;
          pending <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: decodes divisor writes, replicates channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CNT_W   = CNT_W_DFLT,
  parameter int unsigned DEF_DIV = DEF_DIV_DFLT,
  parameter int unsigned SEL_W   = 3
) (
  input logic             Clk,
  input logic             Rst,
  clk_div_multi_if.slave  bus
);

  logic [NUM_CH-1:0] wr_vec;
  logic [NUM_CH-1:0] clk_out_vec;
  logic [NUM_CH-1:0] tick_vec;
  logic [NUM_CH-1:0] pending_vec;

  // Out-of-range selects match no channel, so the write is dropped.
  always_comb begin
    wr_vec = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_vec[i] = bus.DivWr && (bus.DivSel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .Clk      (Clk),
      .Rst      (Rst),
      .en       (bus.En),
      .sync_all (bus.SyncAll),
      .wr       (wr_vec[g]),
      .wr_data  (bus.DivData),
      .clk_out  (clk_out_vec[g]),
      .tick     (tick_vec[g]),
      .pending  (pending_vec[g])
    );
  end

  assign bus.ClkOut  = clk_out_vec;
  assign bus.Tick    = tick_vec;
  assign bus.Pending = pending_vec;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: per-cycle model compare plus directed literal checks.
module tb_clk_div_multi;

  localparam int NCh = 2;
  localparam int CW  = 25;
  localparam int SW  = 3;
  localparam int Def = 50;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  clk_div_multi_if #(.NUM_CH(NCh), .CNT_W(CW), .SEL_W(SW)) bus ();

  clk_div_multi #(
    .NUM_CH  (NCh),
    .CNT_W   (CW),
    .DEF_DIV (Def),
    .SEL_W   (SW)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  // Model: cycles left in the current half period, level, divisors, strobes.
  typedef struct {
    int left;
    int act;
    int sh;
    bit lvl;
    bit tk;
    bit pd;
  } ch_t;

  ch_t m[NCh];
  bit  model_ok = 1'b0;
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  function automatic int clampi(int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic ch_t mstep(ch_t s, bit rst, bit en, bit sync, bit wr, int data);
    ch_t n = s;
    if (rst) begin
      n.left = Def; n.act = Def; n.sh = Def;
      n.lvl = 1'b0; n.tk = 1'b0; n.pd = 1'b0;
    end else if (sync) begin
      if (wr) n.sh = data;
      n.act = clampi(n.sh);
      n.left = n.act;
      n.lvl = 1'b0; n.tk = 1'b0; n.pd = 1'b0;
    end else begin
      n.tk = 1'b0;
      if (wr) begin
        n.sh = data;
        n.pd = 1'b1;
      end
      if (en) begin
        n.left = s.left - 1;
        if (n.left == 0) begin
          n.lvl  = !s.lvl;
          n.tk   = n.lvl;
          n.act  = clampi(n.sh);
          n.pd   = 1'b0;
          n.left = n.act;
        end
      end
    end
    return n;
  endfunction

  always @(posedge Clk) begin
    for (int i = 0; i < NCh; i++) begin
      m[i] <= mstep(m[i], Rst, bus.En, bus.SyncAll,
                    bus.DivWr && (int'(bus.DivSel) == i), int'(bus.DivData));
    end
    if (Rst) model_ok <= 1'b1;
    cyc <= cyc + 1;
  end

  function automatic logic [5:0] model_vec();
    logic [5:0] v;
    for (int i = 0; i < NCh; i++) begin
      v[4 + i] = m[i].lvl;
      v[2 + i] = m[i].tk;
      v[i]     = m[i].pd;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b want %b", nm, cyc, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wr(input int sel, input int data);
    bus.DivWr   = 1'b1;
    bus.DivSel  = SW'(sel);
    bus.DivData = CW'(data);
    run(1);
    bus.DivWr = 1'b0;
  endtask

  initial begin
    bus.En = 1'b1; bus.SyncAll = 1'b0; bus.DivWr = 1'b0;
    bus.DivSel = '0; bus.DivData = '0;

    fork
      forever begin
        @(negedge Clk);
        if (model_ok) chk("model", {2'b00, bus.ClkOut, bus.Tick, bus.Pending}, {2'b00, model_vec()});
      end
    join_none

    // Reset and default divisor: first rise at 50, period 100.
    run(3);
    chk("rst_out", {2'b0, bus.ClkOut, bus.Tick, bus.Pending}, 8'h00);
    Rst = 1'b0;
    run(49); chk("pre_rise", 8'(bus.ClkOut), 8'h0);
    run(1);  chk("rise50", 8'(bus.ClkOut), 8'h3); chk("tick50", 8'(bus.Tick), 8'h3);
    run(1);  chk("tick_1cyc", 8'(bus.Tick), 8'h0);
    run(48); chk("hi_hold", 8'(bus.ClkOut), 8'h3);
    run(1);  chk("fall100", 8'(bus.ClkOut), 8'h0);
    run(49); chk("lo_hold", 8'(bus.ClkOut), 8'h0);
    run(1);  chk("rise_per", 8'(bus.ClkOut), 8'h3); chk("tick_per", 8'(bus.Tick), 8'h3);

    // Glitch-free update mid high phase.
    run(10);
    wr(0, 4);    chk("pend_set", 8'(bus.Pending), 8'h1);
    run(38);     chk("old_hi", 8'(bus.ClkOut[0]), 8'h1); chk("pend_hold", 8'(bus.Pending), 8'h1);
    run(1);      chk("old_fall", 8'(bus.ClkOut), 8'h0); chk("pend_clr", 8'(bus.Pending), 8'h0);
    run(3);      chk("new_lo", 8'(bus.ClkOut[0]), 8'h0);
    run(1);      chk("new_rise", 8'(bus.Tick[0]), 8'h1);
    run(4);      chk("new_fall", 8'(bus.ClkOut[0]), 8'h0);
    run(4);      chk("new_per8", 8'(bus.Tick[0]), 8'h1);

    // Write on ch1's TC bypasses; out-of-range select ignored.
    run(37);
    wr(1, 5);    chk("byp_rise", 8'(bus.Tick[1]), 8'h1); chk("byp_pend", 8'(bus.Pending[1]), 8'h0);
    run(4);      chk("byp_hi", 8'(bus.ClkOut[1]), 8'h1);
    run(1);      chk("byp_fall", 8'(bus.ClkOut[1]), 8'h0);
    run(5);      chk("byp_per10", 8'(bus.Tick[1]), 8'h1);
    wr(5, 7);    chk("sel_oor", 8'(bus.Pending), 8'h0);
    run(9);      chk("oor_noeff", 8'(bus.Tick[1]), 8'h1);

    // Divisor 0 and 1 both toggle every cycle.
    wr(0, 0);
    wr(1, 1);
    bus.SyncAll = 1'b1; run(1); bus.SyncAll = 1'b0;
    chk("sync_lo", {2'b0, bus.ClkOut, bus.Tick, bus.Pending}, 8'h00);
    run(1); chk("d01_a", {4'b0, bus.ClkOut, bus.Tick}, 8'h0f);
    run(1); chk("d01_b", {4'b0, bus.ClkOut, bus.Tick}, 8'h00);
    run(1); chk("d01_c", {4'b0, bus.ClkOut, bus.Tick}, 8'h0f);

    // Freeze, resume, then phase-aligned restart with 3 and 6.
    bus.En = 1'b0; run(20);
    chk("frz", {4'b0, bus.ClkOut, bus.Tick}, 8'h0c);
    bus.En = 1'b1;
    run(1); chk("res_a", 8'(bus.ClkOut), 8'h0);
    run(1); chk("res_b", {4'b0, bus.ClkOut, bus.Tick}, 8'h0f);
    wr(0, 3);
    bus.DivWr = 1'b1; bus.DivSel = SW'(1); bus.DivData = CW'(6); bus.SyncAll = 1'b1;
    run(1);
    bus.DivWr = 1'b0; bus.SyncAll = 1'b0;
    chk("sync2", {2'b0, bus.ClkOut, bus.Tick, bus.Pending}, 8'h00);
    run(3);  chk("s3", {4'b0, bus.ClkOut, bus.Tick}, 8'h05);
    run(3);  chk("s6", {4'b0, bus.ClkOut, bus.Tick}, 8'h0a);
    run(3);  chk("s9", {4'b0, bus.ClkOut, bus.Tick}, 8'h0d);
    run(3);  chk("s12", 8'(bus.ClkOut), 8'h0);
    run(12); chk("s24", 8'(bus.ClkOut), 8'h0);

    // Reset with a pending write discards it.
    wr(0, 9); chk("pend_pre", 8'(bus.Pending), 8'h1);
    Rst = 1'b1; run(1);
    chk("rst_mid", {2'b0, bus.ClkOut, bus.Tick, bus.Pending}, 8'h00);
    Rst = 1'b0;
    run(49); chk("rst_lo", 8'(bus.ClkOut), 8'h0);
    run(1);  chk("rst_def", 8'(bus.ClkOut), 8'h3);
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
